regfile_writeback_stage: RTL
============================

REGFILE_WRITEBACK_STAGE -- requirements
Module: regfile_writeback_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on posedge.
REQ-003 SHALL have port nRst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_valid  in  1  MEM stage holds a real instruction.
REQ-005 SHALL have port mem_regwr  in  1  instruction writes a register.
REQ-006 SHALL have port mem_wsel  in  5  destination register index.
REQ-007 SHALL have port mem_wbsrc  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 LUI.
REQ-008 SHALL have ports mem_aluout, mem_dload, mem_npc  in  32 each  ALU result, load data, PC+4.
REQ-009 SHALL have port mem_imm16  in  16  LUI immediate.
REQ-010 SHALL have port mem_halt  in  1  instruction is HALT.
REQ-011 SHALL have ports stall, flush  in  1 each  hold stage / insert bubble.
REQ-012 SHALL have ports wb_WEN out 1, wb_wsel out 5, wb_wdat out 32  register-file write port.
REQ-013 SHALL have port halt  out  1  core halted, sticky.
REQ-014 SHALL have port retired  out  CNT_W  count of retired instructions.

Function
REQ-015 SHALL latch all mem_* fields into a stage register at posedge when stall=0 and flush=0.
REQ-016 SHALL clear latched valid (bubble) at posedge when flush=1; flush wins over stall.
REQ-017 SHALL hold every latched field unchanged at posedge when stall=1 and flush=0.
REQ-018 SHALL drive wb_WEN = valid & regwr & (wsel!=0) & (state==RUN), from latched fields only (no mem_* combinational path).
REQ-019 SHALL drive wb_wsel = latched wsel at all times.
REQ-020 SHALL select wb_wdat combinationally from latched fields: 00 aluout, 01 dload, 10 npc, 11 {imm16,16'h0000}.
REQ-021 SHALL produce one-cycle latency: instruction captured at posedge N drives write port during cycle N; register file commits it at the following negedge.
REQ-022 SHALL implement FSM states RUN, HALTED; reset state RUN.
REQ-023 SHALL transition RUN->HALTED at posedge when a latched valid instruction has halt=1 and stall=0; HALTED is terminal until reset.
REQ-024 SHALL assert halt=1 iff state==HALTED.
REQ-025 SHALL in HALTED ignore all captures (valid forced 0) and hold wb_WEN=0.
REQ-026 SHALL increment retired at each posedge where state==RUN, latched valid=1, stall=0, counting the HALT itself.
REQ-027 SHALL saturate retired at 2^CNT_W-1 (no wrap).
REQ-028 SHALL not retire or halt on a flushed mem_halt (bubble has valid=0).
REQ-029 SHALL retire a stalled instruction exactly once, when it leaves the stage.

Reset
REQ-030 SHALL on nRst=0 immediately clear valid, regwr, wsel, wbsrc, data fields to 0, state to RUN, retired to 0, regardless of clk.
REQ-031 SHALL therefore present wb_WEN=0, wb_wsel=0, wb_wdat=0, halt=0, retired=0 during reset.
REQ-032 SHALL abandon any in-flight instruction when reset asserts mid-operation; no write is issued after release until a new capture.

Verification
REQ-033 SHALL pass: capture valid regwr wsel=5 wbsrc=00 aluout=0xDEADBEEF -> next cycle wb_WEN=1, wb_wsel=5, wb_wdat=0xDEADBEEF, retired=1 after following posedge.
REQ-034 SHALL pass: wsel=0 regwr=1 wbsrc=11 imm16=0x1234 -> wb_WEN=0, wb_wdat=0x12340000, retired still increments.
REQ-035 SHALL pass: stall=1 for 3 cycles holding load dload=0x55 -> wb_wdat=0x55 stable 3 cycles, retired +1 only on release.
REQ-036 SHALL pass: stall=1 and flush=1 same posedge -> valid=0, wb_WEN=0, retired unchanged.
REQ-037 SHALL pass: HALT captured, then further valid regwr instructions -> halt=1 after next posedge, wb_WEN=0 thereafter, retired frozen; nRst pulse -> halt=0, retired=0.
REQ-038 SHALL pass: CNT_W=4, retire 20 instructions -> retired=15 saturated.

Source files
------------

// File: rtl/regfile_writeback_stage.sv
// Writeback stage: latches the MEM-stage instruction, drives the register-file write port
// one cycle later, counts retired instructions and stops the core on HALT.
module regfile_writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             mem_valid,
  input  logic             mem_regwr,
  input  logic [4:0]       mem_wsel,
  input  logic [1:0]       mem_wbsrc,
  input  logic [31:0]      mem_aluout,
  input  logic [31:0]      mem_dload,
  input  logic [31:0]      mem_npc,
  input  logic [15:0]      mem_imm16,
  input  logic             mem_halt,
  input  logic             stall,
  input  logic             flush,
  output logic             wb_WEN,
  output logic [4:0]       wb_wsel,
  output logic [31:0]      wb_wdat,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic        valid;
    logic        regwr;
    logic [4:0]  wsel;
    logic [1:0]  wbsrc;
    logic [31:0] aluout;
    logic [31:0] dload;
    logic [31:0] npc;
    logic [15:0] imm16;
    logic        halt;
  } stage_t;

  state_t state, state_nxt;
  stage_t st;
  logic   retire;

  // The latched instruction leaves the stage (retires) on any unstalled edge.
  assign retire = (state == RUN) && st.valid && !stall;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (retire && st.halt) state_nxt = HALTED;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      st <= '0;
    end else if (flush) begin
      st.valid <= 1'b0;
    end else if (!stall) begin
      // Once halted (or halting on this edge) nothing new is accepted.
      st.valid  <= mem_valid && (state_nxt == RUN);
      st.regwr  <= mem_regwr;
      st.wsel   <= mem_wsel;
      st.wbsrc  <= mem_wbsrc;
      st.aluout <= mem_aluout;
      st.dload  <= mem_dload;
      st.npc    <= mem_npc;
      st.imm16  <= mem_imm16;
      st.halt   <= mem_halt;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                      retired <= '0;
    else if (retire && ~&retired)   retired <= retired + CNT_W'(1);
  end

  assign wb_WEN  = st.valid && st.regwr && (st.wsel != 5'd0) && (state == RUN);
  assign wb_wsel = st.wsel;
  assign halt    = (state == HALTED);

  always_comb begin
    wb_wdat = st.aluout;
    case (st.wbsrc)
      2'b00: wb_wdat = st.aluout;
      2'b01: wb_wdat = st.dload;
      2'b10: wb_wdat = st.npc;
      2'b11: wb_wdat = {st.imm16, 16'h0000};
      default: wb_wdat = st.aluout;
    endcase
  end

endmodule
